// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs field-level instructions (op, rd, rs1, rs2, imm) into 16-bit ISA
//   words and writes them sequentially into instruction memory starting at a
//   programmable base address.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start, base_addr  begin a load session (taken only in IDLE/ERROR)
//   in_*              field bundle stream, valid/ready handshake
//   imem_wr_*         instruction memory write port (held until imem_wr_rdy)
//   busy, done, err   session status; done is a one-cycle pulse
//   err_code          0 none, 1 illegal opcode, 2 address overflow
//   instr_count       words written in the current/last session
module instr_encoder_loader #(
    parameter int PC_ADDR_WIDTH  = 8,
    parameter int INST_MSG_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [PC_ADDR_WIDTH-1:0]  base_addr,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [3:0]                in_op,
    input  logic [3:0]                in_rd,
    input  logic [3:0]                in_rs1,
    input  logic [3:0]                in_rs2,
    input  logic [7:0]                in_imm,
    input  logic                      in_last,
    output logic                      imem_wr_en,
    output logic [PC_ADDR_WIDTH-1:0]  imem_wr_addr,
    output logic [INST_MSG_WIDTH-1:0] imem_wr_data,
    input  logic                      imem_wr_rdy,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [PC_ADDR_WIDTH:0]    instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0]               OP_MAX   = 4'd12;
    localparam logic [PC_ADDR_WIDTH-1:0] ADDR_ONE = {{(PC_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PC_ADDR_WIDTH:0]   CNT_ONE  = {{PC_ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                      state_q, state_d;
    logic [PC_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [INST_MSG_WIDTH-1:0]   data_q, data_d;
    logic                        last_q, last_d;
    logic [PC_ADDR_WIDTH:0]      count_q, count_d;
    logic [1:0]                  err_code_q, err_code_d;

    // Fields a given opcode does not use are forced to zero.
    function automatic logic [INST_MSG_WIDTH-1:0] encode(
        input logic [3:0] op,
        input logic [3:0] rd,
        input logic [3:0] rs1,
        input logic [3:0] rs2,
        input logic [7:0] imm
    );
        logic [INST_MSG_WIDTH-1:0] w;
        w = '0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: w = {op, rd, rs1, rs2};
            4'd8:                   w = {op, rd, imm};
            4'd9:                   w = {op, rd, rs1, 4'h0};
            4'd10:                  w = {op, 4'h0, rs1, rs2};
            default:                w = {op, 12'h000};
        endcase
        return w;
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;
        count_d    = count_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    addr_d     = base_addr;
                    count_d    = '0;
                    err_code_d = 2'd0;
                    state_d    = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (in_val) begin
                    if (in_op > OP_MAX) begin
                        err_code_d = 2'd1;
                        state_d    = S_ERROR;
                    end else begin
                        data_d  = encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
                        last_d  = in_last;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (imem_wr_rdy) begin
                    count_d = count_q + CNT_ONE;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (&addr_q) begin
                        // No wrap: the next word would land outside imem.
                        err_code_d = 2'd2;
                        state_d    = S_ERROR;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_ACCEPT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
        end
    end

    assign in_rdy       = (state_q == S_ACCEPT);
    assign imem_wr_en   = (state_q == S_WRITE);
    assign busy         = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERROR);
    assign err_code     = err_code_q;
    assign imem_wr_addr = addr_q;
    assign imem_wr_data = data_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: the stimulus side pushes the
// expected (addr, data) of every legal bundle; a monitor pops and compares on
// each accepted memory write and checks that held writes stay stable.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_val;
    logic        in_rdy;
    logic [3:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [7:0]  in_imm;
    logic        in_last;
    logic        imem_wr_en;
    logic [7:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic        imem_wr_rdy;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [8:0]  instr_count;

    instr_encoder_loader #(.PC_ADDR_WIDTH(8), .INST_MSG_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_val(in_val), .in_rdy(in_rdy), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data), .imem_wr_rdy(imem_wr_rdy),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 1;     // 0 random, 1 always ready, 2 never ready
    logic [7:0] m_addr;
    int   m_count;
    int   end_kind;         // 0 open, 1 done, 2 illegal op, 3 overflow
    logic       pend = 1'b0;
    logic [7:0] p_addr;
    logic [15:0] p_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding straight from the ISA field layout.
    function automatic logic [15:0] model_enc(input int op, input int rd, input int rs1,
                                              input int rs2, input int imm);
        int w;
        w = op * 4096;
        if (op < 8)        w += rd * 256 + rs1 * 16 + rs2;
        else if (op == 8)  w += rd * 256 + imm;
        else if (op == 9)  w += rd * 256 + rs1 * 16;
        else if (op == 10) w += rs1 * 16 + rs2;
        return w[15:0];
    endfunction

    // Memory-side ready, changed away from both clock edges.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1:       imem_wr_rdy = 1'b1;
            2:       imem_wr_rdy = 1'b0;
            default: imem_wr_rdy = ($urandom % 3) != 0;
        endcase
    end

    // Monitor: compare every accepted write, and check stalled writes hold.
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("wr_hold_en", imem_wr_en, 1);
                chk("wr_hold_addr", imem_wr_addr, p_addr);
                chk("wr_hold_data", imem_wr_data, p_data);
            end
            if (imem_wr_en) begin
                chk("in_rdy_during_write", in_rdy, 0);
                if (imem_wr_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("wr_addr", imem_wr_addr, mon_e.addr);
                        chk("wr_data", imem_wr_data, mon_e.data);
                    end
                end
            end
            pend   = imem_wr_en && !imem_wr_rdy;
            p_addr = imem_wr_addr;
            p_data = imem_wr_data;
        end
    end

    task automatic begin_session(input logic [7:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_addr = base;
        m_count = 0;
        end_kind = 0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_in_rdy", in_rdy, 1);
        chk("start_count", instr_count, 0);
        chk("start_err", {err, err_code}, 0);
    endtask

    // exp_word < 0 means use the reference model.
    task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [7:0] imm, input logic last,
                        input int exp_word);
        int t;
        wr_t e;
        t = 0;
        @(negedge clk);
        while (!in_rdy && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_rdy) begin
            chk("in_rdy_timeout", in_rdy, 1);
            end_kind = 0;
            return;
        end
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_val = 1'b1;
        // start/base_addr noise while busy must be ignored.
        start = 1'($urandom % 2);
        base_addr = 8'($urandom);
        if (op <= 4'd12) begin
            e.addr = m_addr;
            e.data = (exp_word < 0) ? model_enc(op, rd, rs1, rs2, imm) : exp_word[15:0];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_val = 1'b0;
        start = 1'b0;
        @(negedge clk);
        if (op > 4'd12) begin
            chk("illegal_err", err, 1);
            chk("illegal_code", err_code, 1);
            chk("illegal_no_write", imem_wr_en, 0);
            chk("illegal_count", instr_count, m_count);
            end_kind = 2;
        end else begin
            chk("latency_wr_en", imem_wr_en, 1);
            m_count++;
            if (last)                end_kind = 1;
            else if (m_addr == 8'hFF) end_kind = 3;
            else                     m_addr = m_addr + 8'd1;
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        if (end_kind == 1) begin
            while (!done && t < 60) begin @(negedge clk); t++; end
            chk("done_seen", done, 1);
            chk("done_count", instr_count, m_count);
            chk("done_busy", busy, 0);
            chk("done_q_empty", exp_q.size(), 0);
            @(negedge clk);
            chk("done_pulse_width", done, 0);
            chk("done_count_hold", instr_count, m_count);
        end else if (end_kind >= 2) begin
            while (!err && t < 60) begin @(negedge clk); t++; end
            chk("err_seen", err, 1);
            chk("err_code", err_code, (end_kind == 2) ? 1 : 2);
            chk("err_count", instr_count, m_count);
            chk("err_in_rdy", in_rdy, 0);
            chk("err_q_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_val = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
        imem_wr_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {in_rdy, imem_wr_en, busy, done, err, err_code, imem_wr_addr, instr_count}, 0);
        chk("reset_data", imem_wr_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic ALU word
        begin_session(8'h10);
        send(4'd0, 4'd3, 4'd1, 4'd2, 8'hFF, 1'b1, 16'h0312);
        wait_end();

        // Unused fields masked
        begin_session(8'h20);
        send(4'd8, 4'd5, 4'hF, 4'hF, 8'hA7, 1'b0, 16'h85A7);
        send(4'd10, 4'hF, 4'd4, 4'd6, 8'hFF, 1'b0, 16'hA046);
        send(4'd11, 4'hF, 4'hF, 4'hF, 8'hFF, 1'b1, 16'hB000);
        wait_end();
        begin_session(8'h28);
        send(4'd7, 4'd9, 4'd2, 4'd3, 8'h55, 1'b1, 16'h7923);
        wait_end();

        // Backpressure: ready low for the first three WRITE cycles
        rdy_mode = 2;
        begin_session(8'h30);
        send(4'd9, 4'd2, 4'd7, 4'hF, 8'hFF, 1'b1, 16'h9270);
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_rdy", in_rdy, 0);
        end
        rdy_mode = 1;
        wait_end();

        // Illegal opcode, then a clean restart from ERROR
        begin_session(8'h40);
        send(4'd1, 4'd1, 4'd2, 4'd3, 8'h00, 1'b0, 16'h1123);
        send(4'hD, 4'd1, 4'd2, 4'd3, 8'h00, 1'b1, -1);
        wait_end();
        begin_session(8'h44);
        send(4'd12, 4'hF, 4'hF, 4'hF, 8'hFF, 1'b1, 16'hC000);
        wait_end();

        // Address overflow: third bundle must never be taken
        begin_session(8'hFE);
        send(4'd2, 4'd1, 4'd1, 4'd1, 8'h00, 1'b0, -1);
        send(4'd3, 4'd2, 4'd2, 4'd2, 8'h00, 1'b0, -1);
        wait_end();
        in_op = 4'd0; in_last = 1'b0; in_val = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("ovf_in_rdy", in_rdy, 0);
            chk("ovf_no_write", imem_wr_en, 0);
        end
        in_val = 1'b0;

        // Reset mid-WRITE aborts the pending write
        rdy_mode = 2;
        begin_session(8'h50);
        send(4'd0, 4'd4, 4'd5, 4'd6, 8'h00, 1'b0, -1);
        #1 reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_outputs", {in_rdy, imem_wr_en, busy, done, err, err_code, imem_wr_addr, instr_count}, 0);
        chk("midrst_data", imem_wr_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        rdy_mode = 1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", {busy, imem_wr_en, done}, 0);
        end

        // Randomized sessions
        rdy_mode = 0;
        for (int s = 0; s < 40; s++) begin
            int n;
            logic [7:0] b;
            b = ($urandom % 4 == 0) ? 8'(8'hF8 + $urandom % 8) : 8'($urandom);
            n = 1 + $urandom % 6;
            begin_session(b);
            for (int i = 0; i < n; i++) begin
                logic [3:0] op;
                op = ($urandom % 10 == 0) ? 4'(13 + $urandom % 3) : 4'($urandom % 13);
                send(op, 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), i == n - 1, -1);
                if (end_kind != 0) break;
            end
            wait_end();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
